// File: rtl/canvas_restorer.sv
// Replays a saved cell canvas from memory onto the VGA plot bus.
// Each stored cell colour is expanded into a CELL_DIMENSION x CELL_DIMENSION block of pixels.
module canvas_restorer #(
  parameter int SCREEN_WIDTH   = 160,
  parameter int SCREEN_HEIGHT  = 120,
  parameter int CELL_DIMENSION = 5,
  parameter int SLOT_STRIDE    = 1024
) (
  input  logic                             iClk,
  input  logic                             iReset,
  input  logic                             iStart,
  input  logic                             iSlotSel,
  input  logic [2:0]                       iQ,
  output logic [14:0]                      oAddress,
  output logic                             oChipSelect,
  output logic                             oWren,
  output logic [2:0]                       oColour,
  output logic [$clog2(SCREEN_WIDTH):0]    oX_pixel,
  output logic [$clog2(SCREEN_HEIGHT):0]   oY_pixel,
  output logic                             oPlot,
  output logic                             oBusy,
  output logic                             oDone
);

  localparam int CELLS_X = SCREEN_WIDTH / CELL_DIMENSION;
  localparam int CELLS_Y = SCREEN_HEIGHT / CELL_DIMENSION;
  localparam int XW      = $clog2(SCREEN_WIDTH) + 1;
  localparam int YW      = $clog2(SCREEN_HEIGHT) + 1;
  localparam int CXW     = $clog2(CELLS_X);
  localparam int CYW     = $clog2(CELLS_Y);
  localparam int PW      = $clog2(CELL_DIMENSION);
  localparam int AW      = 15;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_PLOT, S_NEXT, S_DONE
  } state_t;

  state_t          state_q;
  logic            slot_q;
  logic [CXW-1:0]  cx_q;
  logic [CYW-1:0]  cy_q;
  logic [PW-1:0]   px_q;
  logic [PW-1:0]   py_q;
  logic [2:0]      colour_q;
  logic [AW-1:0]   addr_q;
  logic            cs_q;
  logic            plot_q;
  logic            busy_q;
  logic            done_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;

  logic            px_last, py_last, cx_last, cy_last;
  logic [CXW-1:0]  cx_d;
  logic [CYW-1:0]  cy_d;
  logic [PW-1:0]   px_d;
  logic [PW-1:0]   py_d;
  logic [XW-1:0]   x_base;
  logic [YW-1:0]   y_base;

  function automatic logic [AW-1:0] cell_addr(input logic s, input logic [CXW-1:0] cx,
                                               input logic [CYW-1:0] cy);
    return AW'(s) * AW'(SLOT_STRIDE) + AW'(cy) * AW'(CELLS_X) + AW'(cx);
  endfunction

  assign px_last = (px_q == PW'(CELL_DIMENSION - 1));
  assign py_last = (py_q == PW'(CELL_DIMENSION - 1));
  assign cx_last = (cx_q == CXW'(CELLS_X - 1));
  assign cy_last = (cy_q == CYW'(CELLS_Y - 1));

  assign px_d = px_last ? '0 : px_q + 1'b1;
  assign py_d = px_last ? py_q + 1'b1 : py_q;
  assign cx_d = cx_last ? '0 : cx_q + 1'b1;
  assign cy_d = cx_last ? cy_q + 1'b1 : cy_q;

  assign x_base = XW'(cx_q) * XW'(CELL_DIMENSION);
  assign y_base = YW'(cy_q) * YW'(CELL_DIMENSION);

  // px/py always name the pixel currently on the plot bus, so outputs are loaded with the next pixel.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q  <= S_IDLE;
      slot_q   <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      colour_q <= '0;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      done_q <= 1'b0;
      cs_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            slot_q  <= iSlotSel;
            cx_q    <= '0;
            cy_q    <= '0;
            addr_q  <= cell_addr(iSlotSel, '0, '0);
            cs_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: state_q <= S_WAIT;
        S_WAIT: begin
          colour_q <= iQ;
          px_q     <= '0;
          py_q     <= '0;
          x_q      <= x_base;
          y_q      <= y_base;
          plot_q   <= 1'b1;
          state_q  <= S_PLOT;
        end
        S_PLOT: begin
          if (px_last && py_last) begin
            plot_q  <= 1'b0;
            state_q <= S_NEXT;
          end else begin
            px_q <= px_d;
            py_q <= py_d;
            x_q  <= x_base + XW'(px_d);
            y_q  <= y_base + YW'(py_d);
          end
        end
        S_NEXT: begin
          if (cx_last && cy_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            addr_q  <= cell_addr(slot_q, cx_d, cy_d);
            cs_q    <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oAddress    = addr_q;
  assign oChipSelect = cs_q;
  assign oWren       = 1'b0;
  assign oColour     = colour_q;
  assign oX_pixel    = x_q;
  assign oY_pixel    = y_q;
  assign oPlot       = plot_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;

endmodule

// File: tb/tb_canvas_restorer.sv
// Bench for canvas_restorer: a memory model with garbage outside read-return cycles,
// and a scoreboard queue of expected reads/plots checked by an independent monitor.
module tb_canvas_restorer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iStart = 1'b0;
  logic        iSlotSel = 1'b0;
  logic [2:0]  iQ;
  logic [14:0] oAddress;
  logic        oChipSelect, oWren, oPlot, oBusy, oDone;
  logic [2:0]  oColour;
  logic [8:0]  oX_pixel;
  logic [7:0]  oY_pixel;

  canvas_restorer dut (
    .iClk(clk), .iReset(rst), .iStart(iStart), .iSlotSel(iSlotSel), .iQ(iQ),
    .oAddress(oAddress), .oChipSelect(oChipSelect), .oWren(oWren), .oColour(oColour),
    .oX_pixel(oX_pixel), .oY_pixel(oY_pixel), .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  // Memory model: data for a selected address appears the cycle after chip select.
  logic [2:0]  mem [0:2047];
  logic        rd_v = 1'b0;
  logic [14:0] rd_a = '0;
  logic [2:0]  garb = 3'd0;
  always @(posedge clk) begin
    rd_v <= oChipSelect;
    rd_a <= oAddress;
  end
  always @(negedge clk) garb = 3'($urandom_range(0, 7));
  assign iQ = rd_v ? mem[rd_a[10:0]] : garb;

  typedef struct {
    bit is_plot;
    int addr;
    int x;
    int y;
    int col;
  } ev_t;
  ev_t q[$];
  ev_t e;

  int compared = 0, mismatched = 0;
  int cyc = 0, plot_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, first_busy = 0;
  int first_addr = -1, last_addr = -1, corner = -1;
  bit busy_prev = 1'b0, wren_seen = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    plot_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; first_busy = 0;
    first_addr = -1; last_addr = -1; corner = -1; wren_seen = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (oWren) wren_seen = 1'b1;
      if (oBusy) begin
        busy_cnt++;
        if (!busy_prev) begin
          first_busy = cyc;
          first_addr = int'(oAddress);
        end
      end
      busy_prev = oBusy;
      if (oDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (oChipSelect) begin
        last_addr = int'(oAddress);
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL read: unexpected read at addr %0d, none expected", oAddress);
        end else begin
          e = q.pop_front();
          if (e.is_plot || e.addr != int'(oAddress)) begin
            mismatched++;
            $display("FAIL read: got addr %0d expected %s addr %0d", oAddress,
                     e.is_plot ? "plot not read," : "", e.addr);
          end
        end
      end
      if (oPlot) begin
        plot_cnt++;
        if (oX_pixel == 9'd159 && oY_pixel == 8'd119) corner = int'(oColour);
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL plot: unexpected plot (%0d,%0d) col %0d, none expected",
                   oX_pixel, oY_pixel, oColour);
        end else begin
          e = q.pop_front();
          if (!e.is_plot || e.x != int'(oX_pixel) || e.y != int'(oY_pixel) ||
              e.col != int'(oColour)) begin
            mismatched++;
            $display("FAIL plot: got (%0d,%0d) col %0d expected %s(%0d,%0d) col %0d",
                     oX_pixel, oY_pixel, oColour, e.is_plot ? "" : "read addr, ",
                     e.x, e.y, e.col);
          end
        end
      end
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic push_replay(input int slot);
    ev_t n;
    int a;
    for (int cy = 0; cy < 24; cy++) begin
      for (int cx = 0; cx < 32; cx++) begin
        a = slot * 1024 + cy * 32 + cx;
        n.is_plot = 1'b0; n.addr = a; n.x = 0; n.y = 0; n.col = 0;
        q.push_back(n);
        for (int py = 0; py < 5; py++) begin
          for (int px = 0; px < 5; px++) begin
            n.is_plot = 1'b1; n.addr = 0;
            n.x = cx * 5 + px; n.y = cy * 5 + py; n.col = int'(mem[a]);
            q.push_back(n);
          end
        end
      end
    end
  endtask

  // Returns on the negedge of the first READ cycle.
  task automatic start_replay(input int slot);
    @(negedge clk);
    push_replay(slot);
    iSlotSel = slot[0];
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iSlotSel = ~slot[0];
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 23000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(done_cnt > 0), 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 3'(i % 8);
    for (int i = 0; i < 1024; i++) mem[1024 + i] = 3'((i * 3 + 1) % 8);

    // Reset state
    #1;
    chk("rst_plot", int'(oPlot), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_cs", int'(oChipSelect), 0);
    chk("rst_done", int'(oDone), 0);
    chk("rst_addr", int'(oAddress), 0);
    chk("rst_xy", int'(oX_pixel) + int'(oY_pixel) + int'(oColour), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full slot-0 replay with stray starts and slot changes mid-replay
    clear_stats();
    start_replay(0);
    repeat (98) @(negedge clk);
    pulse_start();
    repeat (4899) @(negedge clk);
    pulse_start();
    wait_done("s0_done_seen");
    repeat (5) @(negedge clk);
    chk("s0_plots", plot_cnt, 19200);
    chk("s0_busy_cycles", busy_cnt, 21504);
    chk("s0_done_count", done_cnt, 1);
    chk("s0_done_latency", done_cyc - first_busy, 21504);
    chk("s0_corner_colour", corner, 767 % 8);
    chk("s0_first_addr", first_addr, 0);
    chk("s0_last_addr", last_addr, 767);
    chk("s0_queue_left", q.size(), 0);

    // Slot-1 replay, start during DONE cycle must be ignored
    clear_stats();
    start_replay(1);
    begin
      int n = 0;
      while (!oDone && n < 23000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("s1_done_seen", int'(oDone), 1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      chk("s1_start_in_done_ignored", int'(oBusy | oChipSelect), 0);
      @(negedge clk);
    end
    chk("s1_first_addr", first_addr, 1024);
    chk("s1_last_addr", last_addr, 1791);
    chk("s1_wren", int'(wren_seen), 0);
    chk("s1_plots", plot_cnt, 19200);
    chk("s1_done_count", done_cnt, 1);
    chk("s1_queue_left", q.size(), 0);

    // Reset in the middle of a PLOT burst
    clear_stats();
    start_replay(0);
    repeat (3000) @(negedge clk);
    chk("pre_reset_plot", int'(oPlot), 1);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("reset_plot", int'(oPlot), 0);
    chk("reset_busy", int'(oBusy), 0);
    chk("reset_cs", int'(oChipSelect), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
    repeat (10) @(negedge clk);
    chk("post_reset_no_plots", plot_cnt, 0);
    chk("post_reset_no_busy", busy_cnt, 0);

    // Fresh replay after reset, mem[0]=3'b101 so first block is colour 5
    for (int i = 0; i < 1024; i++) mem[i] = 3'((i + 5) % 8);
    clear_stats();
    start_replay(0);
    wait_done("r_done_seen");
    repeat (3) @(negedge clk);
    chk("r_first_addr", first_addr, 0);
    chk("r_plots", plot_cnt, 19200);
    chk("r_done_count", done_cnt, 1);
    chk("r_corner_colour", corner, (767 + 5) % 8);
    chk("r_queue_left", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
